fb_vga_out: RTL

Frame-buffer and VGA scan-out stage sitting directly downstream of the screen-fill/drawing units. It accepts pixel plot requests (x, y, 3-bit colour) through a valid/ready handshake, buffers them in a small FIFO, and writes them into a 160x120x3 single-port frame buffer. Concurrently it scans the buffer out as 640x480@60 Hz VGA, with each stored pixel replicated 4x4. The frame buffer is not cleared by reset; clearing it is the fill unit's job.

---
 rtl/fb_vga_out.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fb_vga_out.sv
// fb_vga_out: plot requests pass through a small FIFO into a single-port H_RES x V_RES x 3
// frame buffer, which is scanned out as VGA with every stored pixel replicated 4x4.
module fb_vga_out #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int FIFO_DEPTH = 4,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_en,
  input  logic                        plot,
  input  logic [7:0]                  x,
  input  logic [6:0]                  y,
  input  logic [2:0]                  color,
  output logic                        plot_ready,
  output logic                        vga_r,
  output logic                        vga_g,
  output logic                        vga_b,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        blank_n,
  output logic                        frame_start,
  output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count
);
  localparam int H_VIS   = H_RES * 4;
  localparam int V_VIS   = V_RES * 4;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(H_RES * V_RES);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int EW      = AW + 3;

  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [2:0]    r_rgb;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_blank_n;
  logic          r_frame_start;

  logic [EW-1:0] r_fifo [0:FIFO_DEPTH-1];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;

  logic [2:0]    r_fb [0:H_RES*V_RES-1];

  logic          w_vis;
  logic          w_rd;
  logic          w_we;
  logic          w_full;
  logic          w_empty;
  logic          w_in_range;
  logic          w_push;
  logic [AW-1:0] w_raddr;
  logic [AW-1:0] w_waddr;
  logic [EW-1:0] w_head;
  logic [AW-1:0] w_addr;

  // Handshake: a request transfers on any clk edge where plot && plot_ready are both high;
  // the producer holds x/y/color stable while plot_ready is low.
  assign w_full     = (r_cnt == CNT_FULL);
  assign w_empty    = (r_cnt == '0);
  assign plot_ready = !w_full && !reset;
  assign w_in_range = (int'(x) < H_RES) && (int'(y) < V_RES);
  assign w_push     = plot && plot_ready && w_in_range;

  assign w_vis   = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
  assign w_rd    = pix_en && w_vis;
  assign w_we    = !w_empty && !w_rd;
  assign w_head  = r_fifo[r_rp];

  assign w_raddr = AW'(r_vcnt[VW-1:2]) * AW'(H_RES) + AW'(r_hcnt[HW-1:2]);
  assign w_waddr = AW'(y) * AW'(H_RES) + AW'(x);
  // One shared address: the scan read wins on visible pix_en cycles, the FIFO head otherwise.
  assign w_addr  = w_rd ? w_raddr : w_head[EW-1:3];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wp] <= {w_waddr, color};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + PW'(1);
      end
      if (w_we) begin
        r_rp <= r_rp + PW'(1);
      end
      case ({w_push, w_we})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Frame buffer has no reset: contents survive reset and are cleared by the fill unit.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_fb[w_addr] <= w_head[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_rgb         <= 3'b000;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (pix_en) begin
        // Outputs for the current counter position are registered together on this step.
        r_rgb         <= w_vis ? r_fb[w_addr] : 3'b000;
        r_blank_n     <= w_vis;
        r_hsync       <= !((r_hcnt >= HS_START) && (r_hcnt < HS_END));
        r_vsync       <= !((r_vcnt >= VS_START) && (r_vcnt < VS_END));
        r_frame_start <= (r_hcnt == H_LAST) && (r_vcnt == V_LAST);
        if (r_hcnt == H_LAST) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
        end else begin
          r_hcnt <= r_hcnt + HW'(1);
        end
      end
    end
  end

  assign vga_r          = r_rgb[2];
  assign vga_g          = r_rgb[1];
  assign vga_b          = r_rgb[0];
  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign blank_n        = r_blank_n;
  assign frame_start    = r_frame_start;
  assign dbg_fifo_count = r_cnt;

endmodule
